// File: rtl/spinner_ctrl_if.sv
// Signal bundle between the input-mapping logic and the spinner sequencer.
// The master side drives buttons and mouse packets; the slave side returns the registered controls.
interface spinner_ctrl_if;
    logic       btn_minus;
    logic       btn_plus;
    logic       btn_fast;
    logic [8:0] mouse_in;
    logic       minus;
    logic       plus;
    logic       fast;
    logic       strobe;
    logic [8:0] spin_in;
    logic       src_mouse;

    modport master (
        output btn_minus, btn_plus, btn_fast, mouse_in,
        input  minus, plus, fast, strobe, spin_in, src_mouse
    );

    modport slave (
        input  btn_minus, btn_plus, btn_fast, mouse_in,
        output minus, plus, fast, strobe, spin_in, src_mouse
    );
endinterface

// File: rtl/spinner_ctrl.sv
// Spinner sequencer: strobe divider, button auto-acceleration FSM and
// digital/mouse source arbitration. Every output comes straight from a register.
module spinner_ctrl #(
    parameter int STROBE_DIV    = 200000,
    parameter int HOLD_STROBES  = 8,
    parameter int MOUSE_TIMEOUT = 60
) (
    input  logic          clk,
    input  logic          reset,
    spinner_ctrl_if.slave io
);

    localparam int DIV_W  = $clog2(STROBE_DIV);
    localparam int HOLD_W = $clog2(HOLD_STROBES + 1);
    localparam int TO_W   = $clog2(MOUSE_TIMEOUT + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(STROBE_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_STROBES);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(MOUSE_TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_FAST} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_MINUS, DIR_PLUS} dir_t;

    logic [DIV_W-1:0]  div_q;
    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    dir_t              prev_dir_q;
    logic [TO_W-1:0]   to_q, to_d;
    logic              src_q, src_d;
    logic              hist_q;
    logic              strobe_q, minus_q, plus_q, fast_q;
    logic [8:0]        spin_q;

    dir_t              dir;
    logic              tick;
    logic signed [7:0] delta;
    logic              pkt;
    logic              fwd;

    assign tick  = (div_q == DIV_LAST);
    assign delta = io.mouse_in[7:0];
    assign pkt   = (io.mouse_in[8] != hist_q);
    // Digital input owns the counter: mouse motion is dropped whenever a direction is held.
    assign fwd   = pkt && (delta != 8'sd0) && (dir == DIR_NONE);

    always_comb begin
        dir = DIR_NONE;
        if (io.btn_plus && !io.btn_minus) begin
            dir = DIR_PLUS;
        end else if (io.btn_minus && !io.btn_plus) begin
            dir = DIR_MINUS;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (dir != DIR_NONE) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_W'(1);
                end
            end
            ST_HOLD: begin
                if (dir == DIR_NONE) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else if (dir != prev_dir_q) begin
                    hold_d  = HOLD_W'(1);
                end else if (hold_q == HOLD_MAX) begin
                    state_d = ST_FAST;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            ST_FAST: begin
                if (dir == DIR_NONE) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else if (dir != prev_dir_q) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // A forwarded packet restarts the inactivity window even on a tick cycle.
    always_comb begin
        src_d = src_q;
        to_d  = to_q;
        if (tick) begin
            if (dir != DIR_NONE) begin
                src_d = 1'b0;
                to_d  = '0;
            end else if (src_q) begin
                if (to_q == TO_LAST) begin
                    src_d = 1'b0;
                    to_d  = '0;
                end else begin
                    to_d  = to_q + TO_W'(1);
                end
            end
        end
        if (fwd) begin
            src_d = 1'b1;
            to_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            prev_dir_q <= DIR_NONE;
            to_q       <= '0;
            src_q      <= 1'b0;
            hist_q     <= 1'b0;
            strobe_q   <= 1'b0;
            minus_q    <= 1'b0;
            plus_q     <= 1'b0;
            fast_q     <= 1'b0;
            spin_q     <= '0;
        end else begin
            hist_q   <= io.mouse_in[8];
            div_q    <= tick ? '0 : div_q + DIV_W'(1);
            strobe_q <= tick;
            src_q    <= src_d;
            to_q     <= to_d;
            if (tick) begin
                state_q    <= state_d;
                hold_q     <= hold_d;
                prev_dir_q <= dir;
                minus_q    <= (dir == DIR_MINUS);
                plus_q     <= (dir == DIR_PLUS);
                fast_q     <= io.btn_fast || (state_d == ST_FAST);
            end
            if (fwd) begin
                spin_q <= {~spin_q[8], delta};
            end
        end
    end

    assign io.strobe    = strobe_q;
    assign io.minus     = minus_q;
    assign io.plus      = plus_q;
    assign io.fast      = fast_q;
    assign io.spin_in   = spin_q;
    assign io.src_mouse = src_q;

endmodule

// File: doc/spinner_ctrl.md
Name: spinner_ctrl

Overview:
- Sequencer and arbiter that drives the spinner position counter.
- Generates the periodic strobe and, from digital buttons, the minus/plus/fast controls, with an auto-acceleration state machine.
- Arbitrates between two input sources: digital buttons and mouse/paddle delta packets, with digital priority and a mouse inactivity timeout.
- Sits between the input-mapping logic and the spinner counter; every output is registered.

Parameters:
STROBE_DIV, 200000, strobe period in clk cycles (>=2)
HOLD_STROBES, 8, consecutive same-direction ticks at normal rate before auto-fast engages (>=1)
MOUSE_TIMEOUT, 60, ticks without a forwarded mouse packet before the source reverts to digital (>=1)

Ports:
clk  in  1  system clock; everything on its rising edge
reset  in  1  asynchronous, active-high reset
btn_minus  in  1  digital direction minus
btn_plus  in  1  digital direction plus
btn_fast  in  1  manual fast request
mouse_in  in  9  [8] toggles once per new sample; [7:0] signed delta
minus  out  1  registered minus request, valid while strobe=1
plus  out  1  registered plus request, valid while strobe=1
fast  out  1  registered fast select, valid while strobe=1
strobe  out  1  one-cycle tick pulse
spin_in  out  9  forwarded mouse packet; [8] toggles per packet
src_mouse  out  1  1 = mouse is the active source

Behaviour:
- Reset (asynchronous) clears every output, the divider, the hold and timeout counters, the mouse-bit history register, and puts the FSM in IDLE.
- Divider counts 0..STROBE_DIV-1. Tick = the cycle where the count equals STROBE_DIV-1; the count then wraps to 0.
- On the tick edge, strobe, minus, plus and fast all update together. strobe is high for exactly 1 cycle. minus, plus and fast hold until the next tick.
- dir: plus if btn_plus&~btn_minus; minus if btn_minus&~btn_plus; none otherwise, including when both are pressed.
- FSM states IDLE/HOLD/FAST, evaluated only on ticks:
  - IDLE: dir!=none -> HOLD, hold_cnt=1.
  - HOLD: dir=none -> IDLE. dir!=prev_dir -> HOLD, hold_cnt=1. hold_cnt==HOLD_STROBES -> FAST. Otherwise hold_cnt+1.
  - FAST: dir=none -> IDLE. dir!=prev_dir -> HOLD, hold_cnt=1.
  - prev_dir is latched every tick.
- Per-tick outputs: minus/plus = dir decoded. fast = btn_fast | (next state==FAST).
  - With HOLD_STROBES=8: ticks 1-8 of a held direction give fast=0; tick 9 onward gives fast=1.
- While src_mouse=1 and dir=none, the FSM is forced to IDLE and minus=plus=0.
- Mouse packet = mouse_in[8] differs from the history register (history updated every cycle).
  - After reset the history is 0, so mouse_in[8]=1 at reset release counts as a packet.
  - A packet with delta==0 is ignored: not forwarded, no timeout refresh, no source change.
  - A packet with nonzero delta while dir!=none is dropped (digital priority).
  - Otherwise it is forwarded: the next cycle, spin_in[7:0]=delta and spin_in[8] toggles. src_mouse=1 and timeout_cnt=0.
  - Latency from packet to spin_in: 1 cycle. Back-to-back packets on consecutive cycles are each forwarded.
- Source release:
  - On any tick with dir!=none: src_mouse=0, timeout cleared.
  - On a tick with src_mouse=1 and dir=none: timeout_cnt+1. When it reaches MOUSE_TIMEOUT, src_mouse=0.
- Simultaneous forwarded packet and tick: the packet's timeout clear wins over the increment.
- spin_in holds its last value when idle.
- Reset mid-tick or mid-packet: outputs go to 0 immediately. No pending packet is emitted after release.

Test Plan:
- Reset, STROBE_DIV=4, no inputs -> strobe high 1 cycle in every 4; minus=plus=fast=0; spin_in=0; src_mouse=0.
- btn_plus held, HOLD_STROBES=3 -> ticks 1-3 give plus=1, fast=0; tick 4 onward gives plus=1, fast=1. Switch to btn_minus -> next tick gives minus=1, fast=0.
- Both buttons pressed -> minus=plus=0 and FSM in IDLE. btn_fast alone -> fast=1 on every tick.
- mouse_in toggles with delta=8'hFD, no buttons -> next cycle spin_in={~prev bit8, 8'hFD}, src_mouse=1. Repeat with delta=0 -> spin_in unchanged.
- src_mouse=1, MOUSE_TIMEOUT=2, no packets -> src_mouse=0 after the 2nd tick. Repeat with btn_minus pressed -> src_mouse=0 at the first tick, minus=1.
- Packet arrives while btn_plus held -> packet dropped, spin_in unchanged, src_mouse stays 0. Assert reset mid-hold -> all outputs 0 at once, FSM IDLE.
